matrix_stream_loader: RTL and testbench

Streaming front end for the matrix multiplier. Accepts a size configuration, then a row-major element stream over valid/ready: N*N elements of A followed by N*N elements of B. Assembles both into the multiplier's padded MAX*MAX array layout. Presents the loaded matrices with a hold-until-acknowledged valid.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_index_counter.sv | 38 +++
 rtl/matrix_stream_loader.sv | 129 ++++++++++++
 tb/tb_matrix_stream_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix multiplier front end.
package matrix_pkg;

   localparam int DEFAULT_DATA_WIDTH      = 8;
   localparam int DEFAULT_MATRIX_SIZE_MIN = 3;
   localparam int DEFAULT_MATRIX_SIZE_MAX = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_A = 2'd1,
      ST_LOAD_B = 2'd2,
      ST_DONE   = 2'd3
   } loader_state_t;

   typedef logic [DEFAULT_DATA_WIDTH-1:0] elem_t;

   // Row-major position inside the padded stride x stride array.
   function automatic int flat_index(input int row, input int col,
                                     input int stride = DEFAULT_MATRIX_SIZE_MAX);
      return row * stride + col;
   endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/col walker over an N x N matrix; advances one position per beat, wraps to (0,0) after (N-1,N-1).
// Single-cycle update; only moves when advance is high, so stalls hold the position.
module matrix_index_counter (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       advance,
   input  logic [3:0] size,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic       last
);

   logic col_end;
   logic row_end;

   assign col_end = (col == size - 4'd1);
   assign row_end = (row == size - 4'd1);
   assign last    = col_end && row_end;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? 4'd0 : row + 4'd1;
         end else begin
            col <= col + 4'd1;
         end
      end
   end

endmodule

// File: rtl/matrix_stream_loader.sv
// Loads N x N matrices A then B from a valid/ready stream into padded MAX x MAX arrays; mat_valid rises 2*N*N beats + 1 cycle after cfg.
// in_ready only in load states, cfg_ready only in IDLE; results held until mat_ack. MATRIX_LOADER_TIMEOUT_EN adds an idle-beat watchdog.
module matrix_stream_loader
   import matrix_pkg::*;
#(
   parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter int MATRIX_SIZE_MIN = DEFAULT_MATRIX_SIZE_MIN,
   parameter int MATRIX_SIZE_MAX = DEFAULT_MATRIX_SIZE_MAX,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                                                  clock,
   input  logic                                                  reset,
   input  logic                                                  cfg_valid,
   input  logic [3:0]                                            cfg_size,
   output logic                                                  cfg_ready,
   input  logic                                                  in_valid,
   input  logic [DATA_WIDTH-1:0]                                 in_data,
   output logic                                                  in_ready,
   output logic [DATA_WIDTH*MATRIX_SIZE_MAX*MATRIX_SIZE_MAX-1:0] matrix_a,
   output logic [DATA_WIDTH*MATRIX_SIZE_MAX*MATRIX_SIZE_MAX-1:0] matrix_b,
   output logic [3:0]                                            matrix_size,
   output logic                                                  mat_valid,
   input  logic                                                  mat_ack,
   output logic                                                  size_error,
   output logic                                                  timeout
);

   localparam logic [3:0] SIZE_MIN = 4'(MATRIX_SIZE_MIN);
   localparam logic [3:0] SIZE_MAX = 4'(MATRIX_SIZE_MAX);

   loader_state_t state, state_nxt;
   logic       size_ok;
   logic       cfg_acc;
   logic       beat;
   logic       tmo_hit;
   logic [3:0] row;
   logic [3:0] col;
   logic       last;
   int         wr_idx;

   assign size_ok = (cfg_size >= SIZE_MIN) && (cfg_size <= SIZE_MAX);
   assign cfg_acc = (state == ST_IDLE) && cfg_valid && size_ok;
   assign beat    = in_valid && in_ready;
   assign wr_idx  = flat_index(int'(row), int'(col), MATRIX_SIZE_MAX);

   matrix_index_counter u_index (
      .clock   (clock),
      .reset   (reset),
      .clear   (cfg_acc || tmo_hit),
      .advance (beat),
      .size    (matrix_size),
      .row     (row),
      .col     (col),
      .last    (last)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (cfg_acc) state_nxt = ST_LOAD_A;
         ST_LOAD_A: if (tmo_hit) state_nxt = ST_IDLE;
                    else if (beat && last) state_nxt = ST_LOAD_B;
         ST_LOAD_B: if (tmo_hit) state_nxt = ST_IDLE;
                    else if (beat && last) state_nxt = ST_DONE;
         ST_DONE:   if (mat_ack) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = (state == ST_IDLE);
      in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mat_valid  <= 1'b0;
         size_error <= 1'b0;
      end else begin
         mat_valid  <= (state_nxt == ST_DONE);
         size_error <= (state == ST_IDLE) && cfg_valid && !size_ok;
      end
   end

   // Arrays are wiped on accept so padding outside N x N reads as zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         matrix_a    <= '0;
         matrix_b    <= '0;
         matrix_size <= '0;
      end else if (cfg_acc || tmo_hit) begin
         matrix_a    <= '0;
         matrix_b    <= '0;
         matrix_size <= cfg_acc ? cfg_size : 4'd0;
      end else if (beat) begin
         if (state == ST_LOAD_A) matrix_a[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
         else                    matrix_b[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
      end
   end

`ifdef MATRIX_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   assign tmo_hit = in_ready && !beat && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= tmo_hit;
         if (!in_ready || beat || tmo_hit) idle_cnt <= '0;
         else                              idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
   assign tmo_hit        = 1'b0;
   assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader; build with MATRIX_LOADER_TIMEOUT_EN to include the watchdog case.
module tb_matrix_stream_loader;
   import matrix_pkg::*;

   localparam int DW  = 8;
   localparam int MX  = 10;
   localparam int NE  = MX * MX;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              cfg_valid = 1'b0;
   logic [3:0]        cfg_size = '0;
   logic              cfg_ready;
   logic              in_valid = 1'b0;
   logic [DW-1:0]     in_data = '0;
   logic              in_ready;
   logic [DW*NE-1:0]  matrix_a;
   logic [DW*NE-1:0]  matrix_b;
   logic [3:0]        matrix_size;
   logic              mat_valid;
   logic              mat_ack = 1'b0;
   logic              size_error;
   logic              timeout;

   int    tests_run = 0;
   int    tests_failed = 0;
   elem_t model_a [NE];
   elem_t model_b [NE];

   always #5 clock = ~clock;

   matrix_stream_loader #(
      .DATA_WIDTH      (DW),
      .MATRIX_SIZE_MIN (3),
      .MATRIX_SIZE_MAX (MX),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cfg_valid   (cfg_valid),
      .cfg_size    (cfg_size),
      .cfg_ready   (cfg_ready),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .matrix_a    (matrix_a),
      .matrix_b    (matrix_b),
      .matrix_size (matrix_size),
      .mat_valid   (mat_valid),
      .mat_ack     (mat_ack),
      .size_error  (size_error),
      .timeout     (timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic elem_t get_a(input int i);
      return matrix_a[i*DW +: DW];
   endfunction

   function automatic elem_t get_b(input int i);
      return matrix_b[i*DW +: DW];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NE; i++) begin
         model_a[i] = '0;
         model_b[i] = '0;
      end
   endtask

   task automatic compare_arrays(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < NE; i++) begin
         if (get_a(i) !== model_a[i]) bad++;
         if (get_b(i) !== model_b[i]) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_cfg(input logic [3:0] n);
      cfg_valid = 1'b1;
      cfg_size  = n;
      step();
      cfg_valid = 1'b0;
   endtask

   // Streams A then B with no stalls; value of beat k is base + k.
   task automatic load_full(input int n, input int base);
      for (int k = 0; k < 2 * n * n; k++) begin
         int e;
         e = k % (n * n);
         in_valid = 1'b1;
         in_data  = DW'(base + k);
         if (k < n * n) model_a[(e / n) * MX + (e % n)] = DW'(base + k);
         else           model_b[(e / n) * MX + (e % n)] = DW'(base + k);
         step();
      end
      in_valid = 1'b0;
   endtask

   function automatic elem_t rnd_val(input int k);
      return DW'(k * 7 + 3);
   endfunction

   initial begin
      int k;
      int cyc;
      int idle_run;
      logic drove;

      #2;
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_mat_valid", mat_valid, 0);
      check("rst_matrix_size", matrix_size, 0);
      check("rst_size_error", size_error, 0);
      check("rst_timeout", timeout, 0);
      clear_model();
      compare_arrays("rst_arrays");
      step();
      reset = 1'b1;
      step();

      // N=3, A = 1..9, B = 10..18
      do_cfg(4'd3);
      check("n3_in_ready", in_ready, 1);
      check("n3_cfg_ready", cfg_ready, 0);
      check("n3_mat_valid_early", mat_valid, 0);
      load_full(3, 1);
      check("n3_mat_valid", mat_valid, 1);
      check("n3_size", matrix_size, 3);
      check("n3_a0", get_a(0), 1);
      check("n3_a1", get_a(1), 2);
      check("n3_a2", get_a(2), 3);
      check("n3_a10", get_a(10), 4);
      check("n3_a22", get_a(22), 9);
      check("n3_b0", get_b(0), 10);
      check("n3_b22", get_b(22), 18);
      compare_arrays("n3_arrays");

      // DONE holds while mat_ack is low and other inputs are ignored
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'b1;
         in_data   = 8'hEE;
         cfg_valid = 1'b1;
         cfg_size  = 4'd5;
         step();
         check("done_in_ready", in_ready, 0);
         check("done_cfg_ready", cfg_ready, 0);
         check("done_mat_valid", mat_valid, 1);
      end
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      compare_arrays("done_arrays_stable");
      check("done_size_stable", matrix_size, 3);
      mat_ack = 1'b1;
      step();
      mat_ack = 1'b0;
      check("ack_mat_valid", mat_valid, 0);
      check("ack_cfg_ready", cfg_ready, 1);
      compare_arrays("ack_arrays_kept");

      // illegal sizes below and above range
      do_cfg(4'd2);
      check("err2_pulse", size_error, 1);
      check("err2_cfg_ready", cfg_ready, 1);
      check("err2_in_ready", in_ready, 0);
      step();
      check("err2_pulse_end", size_error, 0);
      do_cfg(4'd11);
      check("err11_pulse", size_error, 1);
      check("err11_cfg_ready", cfg_ready, 1);
      step();
      check("err11_pulse_end", size_error, 0);
      compare_arrays("err_arrays_kept");
      check("err_size_kept", matrix_size, 3);

      // N=10 with random stalls (idle runs kept short)
      clear_model();
      do_cfg(4'd10);
      k = 0;
      cyc = 0;
      idle_run = 0;
      while (k < 200 && cyc < 2000) begin
         drove = (idle_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         in_valid = drove;
         in_data  = rnd_val(k);
         idle_run = drove ? 0 : idle_run + 1;
         step();
         cyc++;
         if (drove) begin
            if (k < 100) model_a[k] = rnd_val(k);
            else         model_b[k - 100] = rnd_val(k);
            k++;
         end
      end
      in_valid = 1'b0;
      check("n10_beats_done", k, 200);
      check("n10_mat_valid", mat_valid, 1);
      check("n10_size", matrix_size, 10);
      check("n10_a99", get_a(99), rnd_val(99));
      check("n10_b99", get_b(99), rnd_val(199));
      compare_arrays("n10_arrays");
      mat_ack = 1'b1;
      step();
      mat_ack = 1'b0;

      // reset mid B-load for N=4
      do_cfg(4'd4);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(100 + i);
         step();
      end
      in_valid = 1'b0;
      check("mid_in_ready", in_ready, 1);
      reset = 1'b0;
      #1;
      check("arst_cfg_ready", cfg_ready, 1);
      check("arst_in_ready", in_ready, 0);
      check("arst_size", matrix_size, 0);
      check("arst_mat_valid", mat_valid, 0);
      clear_model();
      compare_arrays("arst_arrays");
      step();
      reset = 1'b1;
      step();
      do_cfg(4'd3);
      load_full(3, 21);
      check("reload_mat_valid", mat_valid, 1);
      check("reload_size", matrix_size, 3);
      check("reload_a0", get_a(0), 21);
      check("reload_b22", get_b(22), 38);
      compare_arrays("reload_arrays");
      mat_ack = 1'b1;
      step();
      mat_ack = 1'b0;

`ifdef MATRIX_LOADER_TIMEOUT_EN
      do_cfg(4'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(50 + i);
         step();
      end
      in_valid = 1'b0;
      cyc = 0;
      while (timeout !== 1'b1 && cyc < 30) begin
         step();
         cyc++;
      end
      check("tmo_idle_cycles", cyc, 8);
      check("tmo_cfg_ready", cfg_ready, 1);
      check("tmo_size", matrix_size, 0);
      clear_model();
      compare_arrays("tmo_arrays");
      step();
      check("tmo_pulse_end", timeout, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
